byte_rmw_ctrl: RTL
==================

Name: byte_rmw_ctrl

Overview:
Byte-store sequencer feeding the 24-bit data memory, which has no native byte-write support. It accepts one byte-store request at a time, carrying an 18-bit data word and a 3-bit one-hot byte-lane select. It then runs a read-modify-write on the addressed 24-bit word, replacing only the selected 8-bit lane. It sits between the processor store path and the single-port synchronous data RAM.

Parameters:
ADDR_W, 10, word-address width of the data RAM.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  store request present.
req_ready  output  1  block can accept a request; high only in IDLE.
req_addr  input  ADDR_W  word address.
req_byteena  input  3  lane select: 100 = bits 23:16, 010 = bits 15:8, 001 = bits 7:0.
req_data  input  18  store data; only bits 7:0 are used.
mem_addr  output  ADDR_W  RAM address, registered.
mem_rd_en  output  1  RAM read strobe, registered.
mem_rdata  input  24  RAM read data, valid exactly 1 cycle after the cycle in which mem_rd_en is high.
mem_wr_en  output  1  RAM write strobe, registered.
mem_wdata  output  24  merged word, registered.
done  output  1  1-cycle pulse: store committed.
err  output  1  1-cycle pulse: request rejected.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0 except req_ready = 1; state = IDLE; captured request registers = 0.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. Inputs are ignored at all other times. req_valid may stay high across requests; each acceptance is one store.
- States: IDLE, RD, MRG, WR, ERR.
- IDLE: req_ready = 1.
  - On accept with one-hot req_byteena: capture addr, lane, req_data[7:0]; load mem_addr; set mem_rd_en; go to RD.
  - On accept with non-one-hot req_byteena (000, 011, 101, 110, 111): go to ERR. No RAM access.
- RD: mem_rd_en = 1 and mem_addr = captured address are visible; RAM samples them. Clear mem_rd_en; go to MRG.
- MRG: mem_rdata is valid.
  - mem_wdata <= mem_rdata with the selected lane replaced by the captured byte; the other two lanes are unchanged bit-for-bit.
  - Set mem_wr_en and done; go to WR.
- WR: mem_wr_en = 1, done = 1, mem_addr unchanged. Clear mem_wr_en and done; go to IDLE.
- ERR: err = 1, req_ready = 0. Clear err; go to IDLE.
- Latency and throughput: accept edge to first WR cycle = 3 cycles. One store per 4 cycles. Back-to-back requests to the same address are correct because stores are fully serialised; no forwarding is needed.
- req_data[17:8] is ignored, never checked, never an error.
- mem_rdata is sampled only in MRG; its value in all other states is don't-care.
- Reset mid-operation: all state and outputs return to reset values asynchronously. The in-flight request is dropped and not retried. If reset asserts during WR, mem_wr_en falls immediately; the RAM controller may or may not commit that word.
- No combinational path from req_* to any output other than through registers. req_ready is decoded from state only.

Decomposition:
- Package byte_mem_pkg:
  - constants WORD_W = 24, BYTE_W = 8, DIN_W = 18;
  - enum lane_e {LANE_HI = 3'b100, LANE_MID = 3'b010, LANE_LO = 3'b001};
  - enum rmw_state_e {IDLE, RD, MRG, WR, ERR};
  - function is_onehot3.
- Sub-module byte_lane_merge (combinational): inputs old word, byte, lane; output merged word. It is instantiated in MRG and unit-tested separately.

Test Plan:
1. Reset, then RAM[5] = 0xAABBCC. Request addr 5, byteena 100, data 0x3FF11 -> mem_rd_en at cycle 1, mem_wr_en + done at cycle 3, mem_wdata = 0x11BBCC; req_ready low for cycles 1-3.
2. RAM[7] = 0x123456. Requests: byteena 010 data 0x00099, then byteena 001 data 0x000EE, both addr 7, req_valid held high -> writes 0x129956 then 0x1299EE; second accept exactly 4 cycles after first.
3. byteena 000 and then 110 -> err pulses 1 cycle each; mem_rd_en and mem_wr_en never assert; done stays 0; req_ready returns 1 after ERR.
4. rst_n low during MRG -> outputs reach reset values without a clock edge; no mem_wr_en pulse; RAM word unchanged.
5. Random 1000 one-hot stores against a RAM model with 1-cycle read latency -> final RAM contents match the reference byte-write model; done count equals accepted count.
6. req_data[17:8] = 0x3FF with data[7:0] = 0x00, lane 001 on 0xFFFFFF -> mem_wdata = 0xFFFF00.

Source files
------------

// File: rtl/byte_mem_pkg.sv
// Shared widths, lane encodings and FSM states for the byte-store
// read-modify-write path into the 24-bit data RAM.
package byte_mem_pkg;

    localparam int WORD_W = 24;
    localparam int BYTE_W = 8;
    localparam int DIN_W  = 18;

    typedef enum logic [2:0] {
        LANE_HI  = 3'b100,
        LANE_MID = 3'b010,
        LANE_LO  = 3'b001
    } lane_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MRG  = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4
    } rmw_state_e;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Replaces one 8-bit lane of a 24-bit word; the other lanes pass through.
module byte_lane_merge
    import byte_mem_pkg::*;
(
    input  logic [WORD_W-1:0] old_word_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic [2:0]        lane_i,
    output logic [WORD_W-1:0] merged_o
);

    // A non-one-hot lane never reaches here; pass the word through untouched.
    always_comb begin
        merged_o = old_word_i;
        case (lane_i)
            LANE_HI:  merged_o[3*BYTE_W-1:2*BYTE_W] = byte_i;
            LANE_MID: merged_o[2*BYTE_W-1:BYTE_W]   = byte_i;
            LANE_LO:  merged_o[BYTE_W-1:0]          = byte_i;
            default:  merged_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/byte_rmw_ctrl.sv
// Byte-store sequencer: read-modify-write of one lane of a 24-bit RAM word,
// one store at a time, every RAM-facing output registered.
module byte_rmw_ctrl
    import byte_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_byteena,
    input  logic [DIN_W-1:0]  req_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              done,
    output logic              err
);

    rmw_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [2:0]          lane_q, lane_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [WORD_W-1:0]   merged;
    logic                unused_req_data;

    // Upper store-data bits carry no meaning for a byte store.
    assign unused_req_data = ^req_data[DIN_W-1:BYTE_W];

    byte_lane_merge u_merge (
        .old_word_i (mem_rdata),
        .byte_i     (byte_q),
        .lane_i     (lane_q),
        .merged_o   (merged)
    );

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        lane_d     = lane_q;
        byte_d     = byte_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (is_onehot3(req_byteena)) begin
                        lane_d     = req_byteena;
                        byte_d     = req_data[BYTE_W-1:0];
                        mem_addr_d = req_addr;
                        rd_en_d    = 1'b1;
                        state_d    = RD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            RD:  state_d = MRG;
            MRG: begin
                wdata_d = merged;
                wr_en_d = 1'b1;
                done_d  = 1'b1;
                state_d = WR;
            end
            WR:      state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            lane_q     <= '0;
            byte_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            lane_q     <= lane_d;
            byte_q     <= byte_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_rd_en = rd_en_q;
    assign mem_wr_en = wr_en_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
